// File: rtl/adf4159_pkg.sv
// Shared definitions for the ADF4159 SPI loopback receiver:
// register indices, decoded field positions and the receive FSM states.
package adf4159_pkg;

  // Control-field values (word[2:0]) selecting each register
  localparam logic [2:0] ADF_R0 = 3'd0;
  localparam logic [2:0] ADF_R1 = 3'd1;
  localparam logic [2:0] ADF_R2 = 3'd2;
  localparam logic [2:0] ADF_R3 = 3'd3;
  localparam logic [2:0] ADF_R4 = 3'd4;
  localparam logic [2:0] ADF_R5 = 3'd5;
  localparam logic [2:0] ADF_R6 = 3'd6;
  localparam logic [2:0] ADF_R7 = 3'd7;

  // Field positions inside the 32-bit register words
  localparam int INT_LSB       = 15;  // R0
  localparam int INT_MSB       = 26;
  localparam int FRAC_MSB_LSB  = 3;   // R0: upper 12 FRAC bits
  localparam int FRAC_MSB_MSB  = 14;
  localparam int FRAC_LSB_LSB  = 15;  // R1: lower 13 FRAC bits
  localparam int FRAC_LSB_MSB  = 27;
  localparam int RDIV_LSB      = 15;  // R2
  localparam int RDIV_MSB      = 19;
  localparam int REF_DBL       = 20;  // R2
  localparam int PRESCALER     = 22;  // R2

  // Receive FSM
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } rx_state_t;

endpackage

// File: rtl/adf4159_rx_sync.sv
// Parameterized-depth synchronizer for one asynchronous SPI line, with an
// extra flop behind it so rising/falling edges can be flagged as pulses.
module adf4159_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the raw input through the synchronizer and keep the previous value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/adf4159_spi_rx.sv
// ADF4159 three-wire SPI loopback receiver: oversamples the bus, assembles
// MSB-first 32-bit words, and keeps the decoded INT/FRAC/R-divider fields.
// Optional feature macro: ADF4159_RX_SHADOW_EN builds an 8x32 shadow bank
// readable through rd_addr/rd_data; without it rd_data is tied to 0.
module adf4159_spi_rx
  import adf4159_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_data,
  input  logic        spi_le,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [2:0]  reg_addr,
  output logic [11:0] ints,
  output logic [24:0] fracs,
  output logic        ref_doubled,
  output logic [4:0]  r_counter,
  output logic        prescaler,
  output logic        frame_err,
  output logic        cfg_done,
  input  logic [2:0]  rd_addr,
  output logic [31:0] rd_data
);

  // Bit order of the synchronized bundle: 0 = spi_clk, 1 = spi_data, 2 = spi_le
  logic [2:0] raw_in;
  logic [2:0] sync_v;
  logic [2:0] rise_v;
  logic [2:0] fall_v;

  assign raw_in = {spi_le, spi_data, spi_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      adf4159_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (raw_in[gi]),
        .sync (sync_v[gi]),
        .rise (rise_v[gi]),
        .fall (fall_v[gi])
      );
    end
  endgenerate

  logic sck_rise, sdi, le_rise, le_fall;
  assign sck_rise = rise_v[0];
  assign sdi      = sync_v[1];
  assign le_rise  = rise_v[2];
  assign le_fall  = fall_v[2];

  rx_state_t   state, state_next;
  logic [5:0]  bit_cnt, cnt_next;
  logic [31:0] sr, sr_next;
  logic        err_next;

  // Next-state logic; a clock edge in the same sample as LE rising is counted first
  always_comb begin
    state_next = state;
    cnt_next   = bit_cnt;
    sr_next    = sr;
    err_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (le_fall) begin
          cnt_next   = 6'd0;
          sr_next    = 32'd0;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sck_rise) begin
          sr_next = {sr[30:0], sdi};
          if (bit_cnt != 6'd63) cnt_next = bit_cnt + 6'd1;
        end
        if (le_rise) begin
          if (cnt_next == 6'd32) begin
            state_next = ST_LATCH;
          end else begin
            err_next   = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_LATCH: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM state, bit counter, shift register and error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= 6'd0;
      sr        <= 32'd0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      bit_cnt   <= cnt_next;
      sr        <= sr_next;
      frame_err <= err_next;
    end
  end

  // Publish the accepted word and update the fields its index owns
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_valid  <= 1'b0;
      cfg_done    <= 1'b0;
      word        <= 32'd0;
      reg_addr    <= 3'd0;
      ints        <= 12'd0;
      fracs       <= 25'd0;
      ref_doubled <= 1'b0;
      r_counter   <= 5'd0;
      prescaler   <= 1'b0;
    end else begin
      word_valid <= (state == ST_LATCH);
      cfg_done   <= (state == ST_LATCH) && (sr[2:0] == ADF_R0);
      if (state == ST_LATCH) begin
        word     <= sr;
        reg_addr <= sr[2:0];
        case (sr[2:0])
          ADF_R0: begin
            ints         <= sr[INT_MSB:INT_LSB];
            fracs[24:13] <= sr[FRAC_MSB_MSB:FRAC_MSB_LSB];
          end
          ADF_R1: fracs[12:0] <= sr[FRAC_LSB_MSB:FRAC_LSB_LSB];
          ADF_R2: begin
            ref_doubled <= sr[REF_DBL];
            r_counter   <= sr[RDIV_MSB:RDIV_LSB];
            prescaler   <= sr[PRESCALER];
          end
          ADF_R3, ADF_R4, ADF_R5, ADF_R6, ADF_R7: ;
        endcase
      end
    end
  end

`ifdef ADF4159_RX_SHADOW_EN
  logic [31:0] shadow [8];

  // Shadow bank: last accepted word per control index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) shadow[i] <= 32'd0;
    end else if (state == ST_LATCH) begin
      for (int i = 0; i < 8; i++) begin
        if (sr[2:0] == 3'(i)) shadow[i] <= sr;
      end
    end
  end

  // Registered readback of the shadow bank
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= 32'd0;
    else      rd_data <= shadow[rd_addr];
  end

  logic unused_bits;
  assign unused_bits = ^{rise_v[1], fall_v[1], fall_v[0]};
`else
  assign rd_data = 32'd0;

  logic unused_bits;
  assign unused_bits = ^{rise_v[1], fall_v[1], fall_v[0], rd_addr};
`endif

endmodule
